// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding and width helpers for the cam lookup-or-insert front end
package cam_pkg;
  localparam int DEF_WIDTH_LOG2 = 5;
  typedef enum logic [2:0] {IDLE, SEARCH, RESOLVE, INSERT, RESP} cam_li_state_t;
  function automatic int iw_of(input int width_log2);
    return width_log2;
  endfunction
  function automatic int dw_of(input int width_log2);
    return 1 << width_log2;
  endfunction
endpackage

// File: rtl/cam_alloc.sv
// cam_alloc: next-free-slot pointer with saturating occupancy count (ptr_o, count_o, full_o)
module cam_alloc #(
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          alloc_i,
  output logic [IW-1:0] ptr_o,
  output logic [IW:0]   count_o,
  output logic          full_o
);
  logic [IW-1:0] r_ptr;
  logic [IW:0]   r_count;
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (alloc_i && !full_o) begin
      r_ptr   <= r_ptr + 1'b1;
      r_count <= r_count + 1'b1;
    end
  end
  assign ptr_o   = r_ptr;
  assign count_o = r_count;
  assign full_o  = r_count[IW];
endmodule

// File: rtl/cam_lookup_insert.sv
// cam_lookup_insert: lookup-or-insert front end driving cam; req/resp valid-ready ports, cam search/write ports, count_o occupancy
module cam_lookup_insert
  import cam_pkg::*;
#(
  parameter int ARRAY_WIDTH_LOG2 = DEF_WIDTH_LOG2,
  parameter int ARRAY_SIZE_LOG2  = DEF_WIDTH_LOG2,
  localparam int IW = iw_of(ARRAY_WIDTH_LOG2),
  localparam int DW = dw_of(ARRAY_WIDTH_LOG2)
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [DW-1:0] req_key_i,
  output logic          resp_valid_o,
  input  logic          resp_ready_i,
  output logic [IW-1:0] resp_index_o,
  output logic          resp_hit_o,
  output logic          resp_full_o,
  output logic [IW:0]   count_o,
  output logic          cam_search_o,
  output logic [DW-1:0] cam_search_data_o,
  output logic          cam_write_o,
  output logic [IW-1:0] cam_write_index_o,
  output logic [DW-1:0] cam_write_data_o,
  input  logic          cam_search_valid_i,
  input  logic [IW-1:0] cam_search_index_i
);
  if (ARRAY_SIZE_LOG2 != ARRAY_WIDTH_LOG2) begin : g_bad_size
    $error("ARRAY_SIZE_LOG2 must equal ARRAY_WIDTH_LOG2");
  end
  cam_li_state_t r_state;
  logic [DW-1:0] r_key;
  logic [IW-1:0] r_index;
  logic          r_hit;
  logic          r_full;
  logic [IW-1:0] w_ptr;
  logic          w_full;
  cam_alloc #(.IW(IW)) u_alloc (
    .clk     (clk),
    .reset_i (reset_i),
    .alloc_i (cam_write_o),
    .ptr_o   (w_ptr),
    .count_o (count_o),
    .full_o  (w_full)
  );
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_index <= '0;
      r_hit   <= 1'b0;
      r_full  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (req_valid_i) begin
          r_key   <= req_key_i;
          r_state <= SEARCH;
        end
        SEARCH: r_state <= RESOLVE;
        RESOLVE: begin
          r_index <= cam_search_valid_i ? cam_search_index_i : '0;
          r_hit   <= cam_search_valid_i;
          r_full  <= !cam_search_valid_i && w_full;
          r_state <= (cam_search_valid_i || w_full) ? RESP : INSERT;
        end
        INSERT: begin
          r_index <= w_ptr;
          r_hit   <= 1'b0;
          r_full  <= 1'b0;
          r_state <= RESP;
        end
        RESP: if (resp_ready_i) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign req_ready_o       = (r_state == IDLE) && !reset_i;
  assign resp_valid_o      = (r_state == RESP);
  assign resp_index_o      = r_index;
  assign resp_hit_o        = r_hit;
  assign resp_full_o       = r_full;
  assign cam_search_o      = (r_state == SEARCH) && !reset_i;
  assign cam_write_o       = (r_state == INSERT) && !reset_i;
  assign cam_search_data_o = r_key;
  assign cam_write_data_o  = r_key;
  assign cam_write_index_o = w_ptr;
endmodule

// File: doc/cam_lookup_insert.md
# cam_lookup_insert

Lookup-or-insert front end that sits directly upstream of `cam` and drives its search and write ports. It accepts one key per transaction on a valid/ready request port and searches the CAM for it. On a hit it returns the matching index. On a miss it writes the key into the next free slot and returns that slot, or reports full. Clients get a single "give me this key's index" operation; they never touch the CAM ports directly.

## Interface
Parameters:
- ARRAY_WIDTH_LOG2, default 5, index width IW; key width DW = 2**IW; capacity 2**IW entries.
- ARRAY_SIZE_LOG2, default 5, must equal ARRAY_WIDTH_LOG2; passed through for `cam` compatibility.

Ports:
- clk  in  1  single clock, rising edge.
- reset_i  in  1  synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_key_i  in  DW  key to look up or insert.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  client consumes the response.
- resp_index_o  out  IW  matched or allocated index.
- resp_hit_o  out  1  key was already present.
- resp_full_o  out  1  miss and table full; nothing written.
- count_o  out  IW+1  occupied entries.
- cam_search_o  out  1  connects to cam search_i.
- cam_search_data_o  out  DW  connects to cam search_data_i.
- cam_write_o  out  1  connects to cam write_i.
- cam_write_index_o  out  IW  connects to cam write_index_i.
- cam_write_data_o  out  DW  connects to cam write_data_i.
- cam_search_valid_i  in  1  from cam search_valid_o.
- cam_search_index_i  in  IW  from cam search_index_o.

## Operation
- FSM states: IDLE, SEARCH, RESOLVE, INSERT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i&&req_ready_o, latch the key into key_q and go to SEARCH.
- SEARCH: cam_search_o=1 and cam_search_data_o=key_q for exactly one cycle, then go to RESOLVE.
- RESOLVE: sample cam_search_valid_i.
  - Hit: latch cam_search_index_i, resp_hit=1, go to RESP.
  - Miss with count_o < 2**IW: go to INSERT.
  - Miss with count_o == 2**IW: resp_full=1, resp_index=0, go to RESP.
- INSERT:
  - cam_write_o=1, cam_write_index_o=alloc_ptr, cam_write_data_o=key_q for one cycle.
  - Latch resp_index=alloc_ptr and resp_hit=0.
  - alloc_ptr increments modulo 2**IW; count_o increments.
  - Go to RESP.
- RESP: resp_valid_o=1 with index, hit and full held stable until resp_ready_i is sampled high, then go to IDLE.
- req_ready_o=0 in every state except IDLE. Requests presented outside IDLE are not accepted and are not lost; the requester holds them.
- cam_search_o and cam_write_o are decoded from state and qualified with !reset_i; both are never high in the same cycle.
- cam_search_data_o and cam_write_data_o both equal key_q at all times.
- alloc_ptr wraps 2**IW-1 -> 0 only on the insert that fills the table; count saturates at 2**IW.
- No deletion. count_o and alloc_ptr return to 0 only on reset.

## Timing
- Reset values: state=IDLE, req_ready_o=1 after reset deasserts (0 during reset), resp_valid_o=0, resp_hit_o=0, resp_full_o=0, resp_index_o=0, count_o=0, alloc_ptr=0, all cam_* outputs 0, key_q=0.
- `cam` search is registered: its result is valid the cycle after search_i is sampled. RESOLVE occupies exactly that cycle.
- Edge 0 = accept edge. Latencies:
  - Hit or full: resp_valid_o high from edge 3.
  - Insert: resp_valid_o high from edge 4.
  - Next acceptance: no earlier than the edge after the resp handshake, so one request is in flight at most.
- Reset mid-operation (any state): next cycle is IDLE with all outputs at reset values. An in-flight request is dropped without a response.
- CAM contents are not cleared by this block, so reset_i must reset `cam` in the same cycle.

## Structure
- Shared package `cam_pkg`:
  - typedef enum `cam_li_state_t` {IDLE, SEARCH, RESOLVE, INSERT, RESP}.
  - Localparam helpers for IW/DW derivation from ARRAY_WIDTH_LOG2.
- One sub-module, `cam_alloc`: alloc_ptr plus saturating count_o, with inputs alloc_i and reset_i and outputs ptr_o, count_o, full_o.

## Test plan
All scenarios use IW=5 (32 entries, 32-bit keys) and the bench instantiates `cam_lookup_insert` wired to `cam`.
1. Reset, then request key 32'h0000_0005:
   - Edge 3: cam_write_o=1, index 0, data 5.
   - Edge 4: resp_valid_o=1, hit=0, index=0; count_o=1.
2. Request key 5 again:
   - Edge 1: cam_search_o=1.
   - Edge 3: resp_valid_o, hit=1, index=0.
   - No cam_write_o pulse; count_o stays 1.
3. Request keys 1..32 in turn (after reset):
   - Responses carry indices 0..31; count_o=32.
   - Key 33 then returns full=1, index=0, with no write pulse.
   - Key 17 still hits at index 16.
4. Hold resp_ready_i=0 for 5 cycles with a second request pending:
   - resp_* stays stable and req_ready_o=0.
   - The second request is accepted only on the edge after resp_ready_i=1.
5. Assert reset_i during INSERT:
   - cam_write_o is low in the reset cycle.
   - Next cycle: IDLE, count_o=0, resp_valid_o=0.
   - A following request for key 9 allocates index 0.
